// File: rtl/roi_pkg.sv
// rtl/roi_pkg.sv - shared FSM encoding and default geometry for the ROI crop engine
package roi_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, ACTIVE, DONE, BLOCKED} roi_state_t;

  localparam int DEF_IMG_W   = 1024;
  localparam int DEF_IMG_H   = 768;
  localparam int DEF_MAX_ROI = 128;
  localparam int MAX_SHIFT   = 2;
endpackage

// File: rtl/roi_cfg_check.sv
// rtl/roi_cfg_check.sv - combinational legality check of an ROI window configuration
module roi_cfg_check
  import roi_pkg::*;
#(
  parameter int COORD_W = 11,
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int MAX_ROI = DEF_MAX_ROI
) (
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] w,
  input  logic [COORD_W-1:0] h,
  input  logic [1:0]         shift,
  output logic               legal
);
  localparam logic [COORD_W:0]   IMG_W_L   = (COORD_W+1)'(IMG_W);
  localparam logic [COORD_W:0]   IMG_H_L   = (COORD_W+1)'(IMG_H);
  localparam logic [COORD_W-1:0] MAX_ROI_L = COORD_W'(MAX_ROI);

  logic [COORD_W:0]   x_end;
  logic [COORD_W:0]   y_end;
  logic [COORD_W-1:0] step_mask;

  // Sums carry one extra bit so a window running off the image cannot wrap back in
  always_comb begin
    x_end     = {1'b0, x0} + {1'b0, w};
    y_end     = {1'b0, y0} + {1'b0, h};
    step_mask = ~({COORD_W{1'b1}} << shift);
    legal     = (w != '0) && (h != '0)
             && (x_end <= IMG_W_L) && (y_end <= IMG_H_L)
             && ((w >> shift) <= MAX_ROI_L) && ((h >> shift) <= MAX_ROI_L)
             && ((w & step_mask) == '0) && ((h & step_mask) == '0)
             && (shift <= 2'(MAX_SHIFT));
  end
endmodule

// File: rtl/roi_crop_engine.sv
// rtl/roi_crop_engine.sv - crops a programmable, optionally decimated window from a raster pixel stream
module roi_crop_engine
  import roi_pkg::*;
#(
  parameter int PIX_W   = 16,
  parameter int COORD_W = 11,
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int MAX_ROI = DEF_MAX_ROI,
  localparam int ROI_W  = $clog2(MAX_ROI)
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic [PIX_W-1:0]   pixel_in,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic               pixel_valid,
  input  logic               frame_vsync,
  input  logic [COORD_W-1:0] cfg_x0,
  input  logic [COORD_W-1:0] cfg_y0,
  input  logic [COORD_W-1:0] cfg_w,
  input  logic [COORD_W-1:0] cfg_h,
  input  logic [1:0]         cfg_shift,
  output logic [PIX_W-1:0]   roi_pixel,
  output logic [ROI_W-1:0]   roi_x,
  output logic [ROI_W-1:0]   roi_y,
  output logic               roi_valid,
  output logic               roi_sof,
  output logic               roi_eol,
  output logic               roi_frame_done,
  output logic               roi_frame_abort,
  output logic               cfg_err
);
  logic               vsync_d1;
  logic               frame_start;
  logic [COORD_W-1:0] sh_x0, sh_y0, sh_w, sh_h;
  logic [1:0]         sh_shift;
  logic [COORD_W-1:0] nx_x0, nx_y0, nx_w, nx_h;
  logic [1:0]         nx_shift;
  logic               nx_legal;
  roi_state_t         state, state_nx;

  logic [COORD_W:0]   x_end, y_end;
  logic [COORD_W-1:0] dx, dy, step, step_mask;
  logic               in_win, aligned, keep, last_x, last_y;

  assign frame_start = frame_vsync & ~vsync_d1;

  // Shadow values as they will be after this edge, so the FSM decides on the new window
  always_comb begin
    nx_x0    = frame_start ? cfg_x0    : sh_x0;
    nx_y0    = frame_start ? cfg_y0    : sh_y0;
    nx_w     = frame_start ? cfg_w     : sh_w;
    nx_h     = frame_start ? cfg_h     : sh_h;
    nx_shift = frame_start ? cfg_shift : sh_shift;
  end

  roi_cfg_check #(
    .COORD_W (COORD_W),
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .MAX_ROI (MAX_ROI)
  ) u_cfg_check (
    .x0    (nx_x0),
    .y0    (nx_y0),
    .w     (nx_w),
    .h     (nx_h),
    .shift (nx_shift),
    .legal (nx_legal)
  );

  always_comb begin
    x_end     = {1'b0, sh_x0} + {1'b0, sh_w};
    y_end     = {1'b0, sh_y0} + {1'b0, sh_h};
    dx        = pixel_x - sh_x0;
    dy        = pixel_y - sh_y0;
    step      = COORD_W'(1) << sh_shift;
    step_mask = step - COORD_W'(1);
    in_win    = (pixel_x >= sh_x0) && ({1'b0, pixel_x} < x_end)
             && (pixel_y >= sh_y0) && ({1'b0, pixel_y} < y_end);
    aligned   = ((dx & step_mask) == '0) && ((dy & step_mask) == '0);
    keep      = pixel_valid && !frame_start && in_win && aligned
             && ((state == ARMED) || (state == ACTIVE));
    last_x    = (dx == sh_w - step);
    last_y    = (dy == sh_h - step);
  end

  always_comb begin
    state_nx = state;
    if (frame_start)
      state_nx = nx_legal ? ARMED : BLOCKED;
    else if (keep && last_x && last_y)
      state_nx = DONE;
    else if (keep)
      state_nx = ACTIVE;
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      vsync_d1        <= 1'b0;
      state           <= IDLE;
      sh_x0           <= '0;
      sh_y0           <= '0;
      sh_w            <= '0;
      sh_h            <= '0;
      sh_shift        <= '0;
      cfg_err         <= 1'b1;
      roi_valid       <= 1'b0;
      roi_pixel       <= '0;
      roi_x           <= '0;
      roi_y           <= '0;
      roi_sof         <= 1'b0;
      roi_eol         <= 1'b0;
      roi_frame_done  <= 1'b0;
      roi_frame_abort <= 1'b0;
    end else begin
      vsync_d1        <= frame_vsync;
      state           <= state_nx;
      sh_x0           <= nx_x0;
      sh_y0           <= nx_y0;
      sh_w            <= nx_w;
      sh_h            <= nx_h;
      sh_shift        <= nx_shift;
      cfg_err         <= ~nx_legal;
      roi_valid       <= keep;
      roi_pixel       <= keep ? pixel_in : '0;
      roi_x           <= keep ? ROI_W'(dx >> sh_shift) : '0;
      roi_y           <= keep ? ROI_W'(dy >> sh_shift) : '0;
      roi_sof         <= keep && (dx == '0) && (dy == '0);
      roi_eol         <= keep && last_x;
      roi_frame_done  <= keep && last_x && last_y;
      roi_frame_abort <= frame_start && (state == ACTIVE);
    end
  end
endmodule

// File: tb/tb_roi_crop_engine.sv
// tb/tb_roi_crop_engine.sv - directed bench for roi_crop_engine
module tb_roi_crop_engine;
  localparam int PIX_W   = 16;
  localparam int COORD_W = 11;
  localparam int ROI_W   = 7;

  logic               pixel_clk = 1'b0;
  logic               rst = 1'b1;
  logic [PIX_W-1:0]   pixel_in = '0;
  logic [COORD_W-1:0] pixel_x = '0, pixel_y = '0;
  logic               pixel_valid = 1'b0, frame_vsync = 1'b0;
  logic [COORD_W-1:0] cfg_x0 = '0, cfg_y0 = '0, cfg_w = '0, cfg_h = '0;
  logic [1:0]         cfg_shift = '0;
  logic [PIX_W-1:0]   roi_pixel;
  logic [ROI_W-1:0]   roi_x, roi_y;
  logic               roi_valid, roi_sof, roi_eol, roi_frame_done, roi_frame_abort, cfg_err;

  roi_crop_engine dut (
    .pixel_clk(pixel_clk), .rst(rst), .pixel_in(pixel_in), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_valid(pixel_valid), .frame_vsync(frame_vsync), .cfg_x0(cfg_x0), .cfg_y0(cfg_y0),
    .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_shift(cfg_shift), .roi_pixel(roi_pixel), .roi_x(roi_x),
    .roi_y(roi_y), .roi_valid(roi_valid), .roi_sof(roi_sof), .roi_eol(roi_eol),
    .roi_frame_done(roi_frame_done), .roi_frame_abort(roi_frame_abort), .cfg_err(cfg_err)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    int x0, y0, w, h, sh;
    int sw, shh;
    bit exp_err;
    int exp_cnt, exp_done;
  } vec_t;
  vec_t vecs[10];

  int n_checks = 0, n_errors = 0;
  int m_x0, m_y0, m_w, m_h, m_sh;
  bit m_stream = 1'b0;
  int cnt_valid, cnt_sof, cnt_eol, cnt_done, cnt_abort;
  int done_x, done_y, done_rx, done_ry;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit v, input int x, input int y);
    int dx, dy, step;
    bit keep, sof, eol, done;
    logic [PIX_W-1:0] d, e_pix;
    logic [ROI_W-1:0] e_x, e_y;
    d = PIX_W'(x * 7 + y * 131 + 23130);
    pixel_valid = v;
    pixel_x = COORD_W'(x);
    pixel_y = COORD_W'(y);
    pixel_in = d;
    step = 1 << m_sh;
    dx = x - m_x0;
    dy = y - m_y0;
    keep = v && m_stream && dx >= 0 && dx < m_w && dy >= 0 && dy < m_h
        && (dx % step == 0) && (dy % step == 0);
    sof  = keep && dx == 0 && dy == 0;
    eol  = keep && dx == m_w - step;
    done = eol && dy == m_h - step;
    e_pix = keep ? d : '0;
    e_x = keep ? ROI_W'(dx / step) : '0;
    e_y = keep ? ROI_W'(dy / step) : '0;
    @(posedge pixel_clk);
    #1;
    if (done) m_stream = 1'b0;
    check($sformatf("pix(%0d,%0d)", x, y),
          {roi_valid, roi_pixel, roi_x, roi_y, roi_sof, roi_eol, roi_frame_done, roi_frame_abort},
          {keep, e_pix, e_x, e_y, sof, eol, done, 1'b0});
    if (roi_valid) cnt_valid++;
    if (roi_sof) cnt_sof++;
    if (roi_eol) cnt_eol++;
    if (roi_frame_abort) cnt_abort++;
    if (roi_frame_done) begin
      cnt_done++;
      done_x = x; done_y = y; done_rx = roi_x; done_ry = roi_y;
    end
  endtask

  task automatic frame(input int x0, y0, w, h, sh, input bit exp_err, input bit exp_abort);
    cfg_x0 = COORD_W'(x0); cfg_y0 = COORD_W'(y0);
    cfg_w = COORD_W'(w); cfg_h = COORD_W'(h); cfg_shift = 2'(sh);
    frame_vsync = 1'b1;
    pixel_valid = 1'b1;
    pixel_x = COORD_W'(x0);
    pixel_y = COORD_W'(y0);
    pixel_in = 16'hbeef;
    @(posedge pixel_clk);
    #1;
    frame_vsync = 1'b0;
    pixel_valid = 1'b0;
    check($sformatf("frame_start(%0d,%0d,%0d,%0d,%0d)", x0, y0, w, h, sh),
          {roi_valid, roi_frame_done, roi_frame_abort, cfg_err},
          {1'b0, 1'b0, exp_abort, exp_err});
    m_x0 = x0; m_y0 = y0; m_w = w; m_h = h; m_sh = sh;
    m_stream = !exp_err;
    cnt_valid = 0; cnt_sof = 0; cnt_eol = 0; cnt_done = 0; cnt_abort = 0;
  endtask

  task automatic rect(input int xa, xb, ya, yb);
    for (int y = ya; y <= yb; y++)
      for (int x = xa; x <= xb; x++)
        cyc(1'b1, x, y);
  endtask

  task automatic counts(input string name, input int e_valid, e_sof, e_eol, e_done);
    check({name, "_valid"}, cnt_valid, e_valid);
    check({name, "_sof"}, cnt_sof, e_sof);
    check({name, "_eol"}, cnt_eol, e_eol);
    check({name, "_done"}, cnt_done, e_done);
  endtask

  initial begin
    //        x0   y0   w    h   sh  sw   shh err cnt  done
    vecs[0] = '{1000, 0,  32,  8,  0, 24,  8,  1,  0,   0};
    vecs[1] = '{992, 760, 32,  8,  0, 32,  8,  0,  256, 1};
    vecs[2] = '{0,   0,   0,   8,  0, 8,   8,  1,  0,   0};
    vecs[3] = '{5,   3,   16,  8,  2, 16,  8,  0,  8,   1};
    vecs[4] = '{0,   0,   8,   8,  3, 8,   8,  1,  0,   0};
    vecs[5] = '{0,   0,   1,   1,  0, 2,   2,  0,  1,   1};
    vecs[6] = '{0,   0,   256, 8,  0, 64,  8,  1,  0,   0};
    vecs[7] = '{20,  10,  112, 8,  1, 112, 8,  0,  224, 1};
    vecs[8] = '{0,   0,   113, 8,  1, 113, 8,  1,  0,   0};
    vecs[9] = '{992, 760, 32,  8,  0, 32,  8,  0,  256, 1};

    repeat (3) @(posedge pixel_clk);
    #1;
    check("reset_outputs",
          {roi_valid, roi_pixel, roi_x, roi_y, roi_sof, roi_eol, roi_frame_done, roi_frame_abort}, 64'd0);
    check("reset_cfg_err", cfg_err, 1);
    rst = 1'b0;
    cyc(1'b1, 0, 0);

    frame(456, 328, 112, 112, 0, 1'b0, 1'b0);
    rect(455, 568, 327, 440);
    counts("center", 12544, 1, 112, 1);
    check("center_done_in", {done_x, done_y}, {32'd567, 32'd439});
    check("center_done_roi", {done_rx, done_ry}, {32'd111, 32'd111});

    frame(0, 0, 256, 256, 1, 1'b0, 1'b0);
    for (int y = 0; y < 256; y++) begin
      if (y % 2 == 0 || y == 1 || y == 255) begin
        for (int x = 0; x < 258; x++) begin
          cyc(1'b1, x, y);
          if (y == 0 && x == 1) check("decim_drop_1_0", roi_valid, 0);
          if (y == 0 && x == 2) check("decim_keep_2_0", {roi_valid, roi_x}, {1'b1, 7'd1});
        end
      end
    end
    counts("decim", 16384, 1, 128, 1);
    check("decim_done_in", {done_x, done_y}, {32'd254, 32'd254});
    check("decim_done_roi", {done_rx, done_ry}, {32'd127, 32'd127});

    for (int i = 0; i < 10; i++) begin
      frame(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].sh, vecs[i].exp_err, 1'b0);
      rect(vecs[i].x0, vecs[i].x0 + vecs[i].sw - 1, vecs[i].y0, vecs[i].y0 + vecs[i].shh - 1);
      check($sformatf("vec%0d_cfg_err", i), cfg_err, vecs[i].exp_err);
      check($sformatf("vec%0d_count", i), cnt_valid, vecs[i].exp_cnt);
      check($sformatf("vec%0d_done", i), cnt_done, vecs[i].exp_done);
    end

    frame(10, 20, 8, 64, 0, 1'b0, 1'b0);
    rect(10, 17, 20, 69);
    counts("pre_abort", 400, 1, 50, 0);
    frame(10, 20, 8, 64, 0, 1'b0, 1'b1);
    rect(10, 17, 20, 83);
    counts("post_abort", 512, 1, 64, 1);
    check("post_abort_pulses", cnt_abort, 0);

    frame(10, 20, 8, 8, 0, 1'b0, 1'b0);
    rect(10, 17, 20, 23);
    cfg_x0 = 11'd100; cfg_y0 = 11'd30; cfg_w = 11'd4; cfg_h = 11'd4;
    rect(10, 17, 24, 27);
    rect(100, 103, 30, 33);
    counts("midcfg_old", 64, 1, 8, 1);
    check("midcfg_done_roi", {done_rx, done_ry}, {32'd7, 32'd7});
    frame(100, 30, 4, 4, 0, 1'b0, 1'b0);
    rect(100, 103, 30, 33);
    counts("midcfg_new", 16, 1, 4, 1);

    frame(0, 0, 16, 16, 0, 1'b0, 1'b0);
    rect(0, 15, 0, 2);
    check("pre_reset_valid", roi_valid, 1);
    rst = 1'b1;
    #2;
    check("async_reset_outputs",
          {roi_valid, roi_pixel, roi_x, roi_y, roi_sof, roi_eol, roi_frame_done, roi_frame_abort}, 64'd0);
    check("async_reset_cfg_err", cfg_err, 1);
    m_stream = 1'b0;
    pixel_valid = 1'b0;
    @(posedge pixel_clk);
    #1;
    rst = 1'b0;
    cnt_valid = 0;
    cnt_abort = 0;
    rect(0, 15, 3, 15);
    check("after_reset_quiet", cnt_valid, 0);
    check("after_reset_no_abort", cnt_abort, 0);
    frame(0, 0, 16, 16, 0, 1'b0, 1'b0);
    rect(0, 15, 0, 15);
    counts("after_reset_frame", 256, 1, 16, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
